// File: rtl/toy_pkg.sv
// Shared RISC_TOY constants: fetch widths, opcode map and the decode NOP word.
package toy_pkg;

    localparam int unsigned TOY_IAW = 30;
    localparam int unsigned TOY_DW  = 32;
    localparam int unsigned TOY_OPW = 5;

    typedef enum logic [TOY_OPW-1:0] {
        OP_ADDI = 5'd0,  OP_ANDI = 5'd1,  OP_ORI  = 5'd2,  OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_NEG  = 5'd6,  OP_NOT  = 5'd7,
        OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_LSR  = 5'd11,
        OP_ASR  = 5'd12, OP_SHL  = 5'd13, OP_ROR  = 5'd14, OP_BR   = 5'd15,
        OP_BRL  = 5'd16, OP_J    = 5'd17, OP_JL   = 5'd18, OP_LD   = 5'd19,
        OP_LDR  = 5'd20, OP_ST   = 5'd21, OP_STR  = 5'd22
    } toy_op_e;

    // ADDI r0, r0, 0: what ID substitutes while ID_VALID is low.
    localparam logic [TOY_DW-1:0] TOY_NOP = {OP_ADDI, 27'd0};

endpackage

// File: rtl/toy_sync_fifo.sv
// Synchronous FIFO with flush; power-of-two DEPTH, head word visible combinationally.
module toy_sync_fifo
    import toy_pkg::*;
#(
    parameter int unsigned W     = TOY_DW + TOY_IAW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Flush wins over push and pop in the same cycle.
    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !flush_i && (cnt_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = PW'(wr_q + 1'b1);
            if (do_pop)  rd_d = PW'(rd_q + 1'b1);
            cnt_d = CW'(cnt_q + CW'(do_push) - CW'(do_pop));
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/toy_fetch_queue.sv
// Prefetch queue front end for RISC_TOY with precise redirect flush.
// Optional TOY_FETCH_BYPASS_EN: empty-queue responses go straight to ID_* in their arrival cycle.
module toy_fetch_queue
    import toy_pkg::*;
#(
    parameter int unsigned    AW       = TOY_IAW,
    parameter int unsigned    DW       = TOY_DW,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    output logic                   IREQ,
    output logic [AW-1:0]          IADDR,
    input  logic [DW-1:0]          INSTR,
    input  logic                   REDIR_VALID,
    input  logic [AW-1:0]          REDIR_ADDR,
    input  logic                   ID_READY,
    output logic                   ID_VALID,
    output logic [DW-1:0]          ID_INSTR,
    output logic [AW-1:0]          ID_PC,
    output logic [$clog2(DEPTH):0] COUNT
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = DW + AW;

    logic          run_q, infl_q, kill_q, kill_d;
    logic [AW-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
    logic [EW-1:0] hold_q, hold_d;
    logic [EW-1:0] head, show;
    logic [CW-1:0] count;
    logic          empty, resp_ok, byp, push, pop;

    toy_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (REDIR_VALID),
        .wdata_i ({INSTR, rpc_q}),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        empty   = (count == '0);
        resp_ok = infl_q && !kill_q;
`ifdef TOY_FETCH_BYPASS_EN
        byp     = empty && resp_ok;
        show    = byp ? {INSTR, rpc_q} : head;
`else
        byp     = 1'b0;
        show    = head;
`endif
        IADDR   = REDIR_VALID ? REDIR_ADDR : fpc_q;
        // A redirect always issues: the queue is being flushed at this edge anyway.
        IREQ    = run_q && (REDIR_VALID || ((count + CW'(infl_q)) < CW'(DEPTH)));
        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        if (IREQ) begin
            fpc_d = AW'(IADDR + 1'b1);
            rpc_d = IADDR;
        end else if (REDIR_VALID) begin
            fpc_d = REDIR_ADDR;
        end
        // The response arriving now is dropped by the flush; only an un-reissued request needs a kill.
        kill_d  = REDIR_VALID && infl_q && !IREQ;
        ID_VALID = !empty || byp;
        {ID_INSTR, ID_PC} = ID_VALID ? show : hold_q;
        hold_d  = ID_VALID ? show : hold_q;
        pop     = !empty && ID_READY;
        push    = resp_ok && !(byp && ID_READY);
        COUNT   = count;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            run_q  <= 1'b0;
            infl_q <= 1'b0;
            kill_q <= 1'b0;
            fpc_q  <= RESET_PC;
            rpc_q  <= '0;
            hold_q <= {TOY_NOP[DW-1:0], AW'(0)};
        end else begin
            run_q  <= 1'b1;
            infl_q <= IREQ;
            kill_q <= kill_d;
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: tb/tb_toy_fetch_queue.sv
// Self-checking bench for toy_fetch_queue: directed table, bypass/wrap/reset sequences, random vs queue model.
module tb_toy_fetch_queue;

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef TOY_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          IREQ, ID_VALID, ID_READY, REDIR_VALID;
    logic [AW-1:0] IADDR, REDIR_ADDR, ID_PC;
    logic [DW-1:0] INSTR, ID_INSTR;
    logic [CW-1:0] COUNT;

    logic          w_ireq, w_valid, w_rdy, w_redir;
    logic [AW-1:0] w_iaddr, w_raddr, w_pc;
    logic [DW-1:0] w_din, w_instr;
    logic [CW-1:0] w_count;

    always #5 CLK = ~CLK;

    toy_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(30'h10)) dut (
        .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .ID_READY(ID_READY),
        .ID_VALID(ID_VALID), .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .COUNT(COUNT)
    );

    toy_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(30'h3FFF_FFFE)) dut_w (
        .CLK(CLK), .RSTN(RSTN), .IREQ(w_ireq), .IADDR(w_iaddr), .INSTR(w_din),
        .REDIR_VALID(w_redir), .REDIR_ADDR(w_raddr), .ID_READY(w_rdy),
        .ID_VALID(w_valid), .ID_INSTR(w_instr), .ID_PC(w_pc), .COUNT(w_count)
    );

    int checks = 0;
    int errors = 0;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a, 2'b11} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched PCs plus the one outstanding request.
    bit            m_run, m_infl;
    logic [AW-1:0] m_fpc, m_ipc, m_last_pc;
    logic [DW-1:0] m_last_instr;
    logic [AW-1:0] m_q[$];
    bit            p_ireq, p_valid, p_byp;
    logic [AW-1:0] p_iaddr, p_pc;
    logic [DW-1:0] p_instr;
    int            p_count;
    bit            mem_v;
    logic [AW-1:0] mem_a;

    task automatic model_reset();
        m_run = 1'b0; m_infl = 1'b0; m_fpc = 30'h10; m_ipc = '0;
        m_last_pc = '0; m_last_instr = '0; m_q.delete();
        mem_v = 1'b0; mem_a = '0;
    endtask

    task automatic predict();
        int n = m_q.size();
        p_byp   = BYP && (n == 0) && m_infl;
        p_ireq  = m_run && (REDIR_VALID || (n + int'(m_infl) < int'(DEPTH)));
        p_iaddr = REDIR_VALID ? REDIR_ADDR : m_fpc;
        p_valid = (n > 0) || p_byp;
        p_pc    = (n > 0) ? m_q[0] : (p_byp ? m_ipc : m_last_pc);
        p_instr = p_valid ? memf(p_pc) : m_last_instr;
        p_count = n;
    endtask

    task automatic drive(input bit rdy, input bit redir, input logic [AW-1:0] raddr);
        ID_READY = rdy; REDIR_VALID = redir; REDIR_ADDR = raddr;
        INSTR = mem_v ? memf(mem_a) : 32'hDEAD_BEEF;
        #1;
        predict();
    endtask

    task automatic check_model();
        chk("mdl_ireq",  IREQ, p_ireq);
        chk("mdl_iaddr", IADDR, p_iaddr);
        chk("mdl_valid", ID_VALID, p_valid);
        chk("mdl_pc",    ID_PC, p_pc);
        chk("mdl_instr", ID_INSTR, p_instr);
        chk("mdl_count", COUNT, p_count);
        chk("count_le_depth", COUNT <= CW'(DEPTH), 1);
    endtask

    task automatic advance();
        if (p_valid) begin m_last_pc = p_pc; m_last_instr = p_instr; end
        if (REDIR_VALID) m_q.delete();
        else begin
            if (p_count > 0 && ID_READY) void'(m_q.pop_front());
            if (m_infl && !(p_byp && ID_READY)) m_q.push_back(m_ipc);
        end
        m_infl = p_ireq;
        if (p_ireq) begin m_ipc = p_iaddr; m_fpc = AW'(p_iaddr + 1'b1); end
        else if (REDIR_VALID) m_fpc = REDIR_ADDR;
        m_run = 1'b1;
        mem_v = IREQ; mem_a = IADDR;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ireq"},  IREQ, 0);
        chk({tag, "_iaddr"}, IADDR, 30'h10);
        chk({tag, "_valid"}, ID_VALID, 0);
        chk({tag, "_instr"}, ID_INSTR, 0);
        chk({tag, "_pc"},    ID_PC, 0);
        chk({tag, "_count"}, COUNT, 0);
    endtask

    typedef struct {
        bit            rdy;
        bit            redir;
        logic [AW-1:0] raddr;
        bit            e_ireq;
        logic [AW-1:0] e_iaddr;
        bit            e_valid;
        logic [AW-1:0] e_pc;
        int            e_count;
    } vec_t;

    vec_t          tbl[17];
    logic [AW-1:0] wrap_exp[3];
    logic [DW-1:0] e_instr;

    initial begin
        RSTN = 1'b0; ID_READY = 1'b0; REDIR_VALID = 1'b0; REDIR_ADDR = '0; INSTR = '0;
        w_rdy = 1'b1; w_redir = 1'b0; w_raddr = '0; w_din = '0;
        model_reset();
        wrap_exp[0] = 30'h3FFF_FFFE; wrap_exp[1] = 30'h3FFF_FFFF; wrap_exp[2] = 30'h0;
        // rdy redir raddr | ireq iaddr valid pc count: fill, backpressure, drain, two redirects
        tbl[0]  = '{0, 0, 30'h0,   0, 30'h10,  0, 30'h0,   0};
        tbl[1]  = '{0, 0, 30'h0,   1, 30'h10,  0, 30'h0,   0};
        tbl[2]  = '{0, 0, 30'h0,   1, 30'h11,  0, 30'h0,   0};
        tbl[3]  = '{0, 0, 30'h0,   1, 30'h12,  1, 30'h10,  1};
        tbl[4]  = '{0, 0, 30'h0,   1, 30'h13,  1, 30'h10,  2};
        tbl[5]  = '{0, 0, 30'h0,   0, 30'h14,  1, 30'h10,  3};
        tbl[6]  = '{0, 0, 30'h0,   0, 30'h14,  1, 30'h10,  4};
        tbl[7]  = '{1, 0, 30'h0,   0, 30'h14,  1, 30'h10,  4};
        tbl[8]  = '{1, 0, 30'h0,   1, 30'h14,  1, 30'h11,  3};
        tbl[9]  = '{1, 0, 30'h0,   1, 30'h15,  1, 30'h12,  2};
        tbl[10] = '{0, 0, 30'h0,   1, 30'h16,  1, 30'h13,  2};
        tbl[11] = '{0, 1, 30'h200, 1, 30'h200, 1, 30'h13,  3};
        tbl[12] = '{1, 0, 30'h0,   1, 30'h201, 0, 30'h13,  0};
        tbl[13] = '{1, 0, 30'h0,   1, 30'h202, 1, 30'h200, 1};
        tbl[14] = '{1, 1, 30'h300, 1, 30'h300, 1, 30'h201, 1};
        tbl[15] = '{1, 0, 30'h0,   1, 30'h301, 0, 30'h201, 0};
        tbl[16] = '{1, 0, 30'h0,   1, 30'h302, 1, 30'h300, 1};

        repeat (3) @(negedge CLK);
        chk_reset_outputs("rst");
        RSTN = 1'b1;

`ifndef TOY_FETCH_BYPASS_EN
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rdy, tbl[i].redir, tbl[i].raddr);
            e_instr = (tbl[i].e_valid || tbl[i].e_pc != '0) ? memf(tbl[i].e_pc) : '0;
            chk("tbl_ireq",  IREQ, tbl[i].e_ireq);
            chk("tbl_iaddr", IADDR, tbl[i].e_iaddr);
            chk("tbl_valid", ID_VALID, tbl[i].e_valid);
            chk("tbl_pc",    ID_PC, tbl[i].e_pc);
            chk("tbl_instr", ID_INSTR, e_instr);
            chk("tbl_count", COUNT, tbl[i].e_count);
            if (i >= 1 && i <= 3) chk("wrap_iaddr", w_iaddr, wrap_exp[i-1]);
            if (i == 3) begin
                chk("wrap_valid", w_valid, 1);
                chk("wrap_pc",    w_pc, 30'h3FFF_FFFE);
                chk("wrap_instr", w_instr, 0);
                chk("wrap_count", w_count, 1);
            end
            advance();
        end
`else
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0);
            check_model();
            if (i >= 1 && i <= 3) chk("wrap_iaddr", w_iaddr, wrap_exp[i-1]);
            if (i == 1) chk("byp_ireq", IREQ, 1);
            if (i == 2) begin
                chk("byp_valid", ID_VALID, 1);
                chk("byp_pc",    ID_PC, 30'h10);
                chk("byp_instr", ID_INSTR, memf(30'h10));
                chk("byp_count", COUNT, 0);
            end
            advance();
        end
`endif

        for (int c = 0; c < 800; c++) begin
            bit            rdy, redir;
            logic [AW-1:0] raddr;
            if (c == 400) begin
                // Asynchronous reset in the middle of a cycle, then refetch from RESET_PC.
                REDIR_VALID = 1'b0;
                #2 RSTN = 1'b0;
                #1 chk_reset_outputs("midrst");
                model_reset();
                @(negedge CLK);
                RSTN = 1'b1;
            end
            rdy   = ((c / 50) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            raddr = ($urandom_range(0, 3) == 0) ? AW'(30'h3FFF_FFFC + 30'($urandom_range(0, 3)))
                                                : AW'($urandom);
            drive(rdy, redir, raddr);
            check_model();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
